// File: rtl/systolic_tile_loader.sv
// Stream-side feeder for a 2x2 systolic array: packs 25 beats into a shadow tile, then runs a
// fixed compute window. Optional macro SYSTOLIC_LOADER_ERRCNT_EN adds a saturating err_cnt output.
module systolic_tile_loader #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned COMPUTE_CYCLES = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  output logic [16*DATA_W-1:0]  in_flat,
  output logic [9*DATA_W-1:0]   fil_flat,
  output logic                  arr_rst,
  output logic                  busy,
  output logic                  tile_done,
`ifdef SYSTOLIC_LOADER_ERRCNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  err_len
);

  localparam logic [4:0] LastIdx = 5'd24;

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [4:0]        beat_cnt_q;
  logic              shadow_full_q;
  logic [7:0]        run_cnt_q;
  logic [DATA_W-1:0] shadow_q [25];

  logic accept, at_last, tile_ok, tile_bad, commit, run_end;

  assign s_ready  = !shadow_full_q;
  assign accept   = s_valid && s_ready;
  assign at_last  = (beat_cnt_q == LastIdx);
  assign tile_ok  = accept && s_last && at_last;
  // Early s_last or a missing s_last on the 25th beat both discard the partial tile.
  assign tile_bad = accept && (s_last != at_last);

  // Shadow storage needs no reset: contents only matter once shadow_full is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow_q[beat_cnt_q] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q    <= '0;
      shadow_full_q <= 1'b0;
      err_len       <= 1'b0;
    end else begin
      err_len <= tile_bad;
      if (accept) begin
        beat_cnt_q <= (tile_ok || tile_bad) ? 5'd0 : beat_cnt_q + 5'd1;
      end
      if (tile_ok) begin
        shadow_full_q <= 1'b1;
      end else if (commit) begin
        shadow_full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (shadow_full_q) state_d = StRun;
      StRun:   if (run_cnt_q == 8'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q == StRun);
    arr_rst = (state_q != StRun);
    commit  = (state_q == StIdle) && shadow_full_q;
    run_end = (state_q == StRun) && (run_cnt_q == 8'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flat   <= '0;
      fil_flat  <= '0;
      run_cnt_q <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= run_end;
      if (commit) begin
        for (int i = 0; i < 16; i++) in_flat[i*DATA_W +: DATA_W] <= shadow_q[i];
        for (int i = 0; i < 9; i++) fil_flat[i*DATA_W +: DATA_W] <= shadow_q[16+i];
        run_cnt_q <= 8'(COMPUTE_CYCLES - 1);
      end else if (busy) begin
        run_cnt_q <= run_cnt_q - 8'd1;
      end
    end
  end

`ifdef SYSTOLIC_LOADER_ERRCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_len && (err_cnt != 8'hff)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/systolic_tile_loader.md
Name: systolic_tile_loader

Overview:
- Stream-side feeder for systolic_two_by_two_module.
- Accepts one 8-bit beat per handshake over a valid/ready stream: 16 input pixels, then 9 filter weights.
- Assembles the beats into a shadow buffer, commits them to the array's parallel in11..in44 / fil11..fil33 operands, then releases the array's active-high reset for a fixed compute window.
- The next tile may load into the shadow buffer while the array computes.

Parameters:
- DATA_W, 8, width of one pixel/weight beat and of each operand element.
- COMPUTE_CYCLES, 24, clk cycles arr_rst is held low per tile. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- s_valid  input  1  beat valid
- s_ready  output  1  loader can accept a beat
- s_data  input  DATA_W  pixel or weight value
- s_last  input  1  marks final beat of a tile (beat index 24)
- in_flat  output  16*DATA_W  input tile; element r,c (0-based) at bits [(4r+c)*DATA_W +: DATA_W]; drives in11..in44
- fil_flat  output  9*DATA_W  filter; element r,c at bits [(3r+c)*DATA_W +: DATA_W]; drives fil11..fil33
- arr_rst  output  1  active-high reset to the array; low only during RUN
- busy  output  1  high while state is RUN
- tile_done  output  1  one-cycle pulse at end of a compute window
- err_len  output  1  one-cycle pulse on a tile-length violation

Behaviour:
- Reset (rst=0, async):
  - in_flat=0, fil_flat=0, arr_rst=1, busy=0, tile_done=0, err_len=0.
  - beat_cnt=0, shadow_full=0, state=IDLE.
  - Shadow contents are don't-care.
- Load side:
  - s_ready = !shadow_full, registered-source combinational.
  - A beat is accepted when s_valid && s_ready.
  - Beat k (k = beat_cnt) writes shadow element k: k 0..15 go to the input tile, k 16..24 go to filter element k-16.
  - beat_cnt increments per accepted beat.
- Length checking:
  - Accepted beat with k=24 and s_last=1: shadow_full<=1, beat_cnt<=0.
  - Accepted beat with s_last=1 and k<24, or k=24 with s_last=0: err_len pulses the next cycle, beat_cnt<=0, shadow_full stays 0 (partial tile discarded).
  - The in_flat/fil_flat outputs are never disturbed by the load side.
- Compute FSM:
  - IDLE: arr_rst=1. If shadow_full=1, on the next edge copy shadow to in_flat/fil_flat, clear shadow_full, set arr_rst<=0, load run_cnt<=COMPUTE_CYCLES-1, go to RUN.
  - RUN: arr_rst=0, busy=1, run_cnt decrements each cycle. When run_cnt=0, on the next edge set arr_rst<=1, pulse tile_done, go to IDLE.
- Latency:
  - Final beat accepted at edge T: shadow_full=1 after T.
  - Commit at T+1: in_flat/fil_flat valid and arr_rst low.
  - arr_rst low for exactly COMPUTE_CYCLES cycles.
  - tile_done high for the cycle after the last RUN cycle.
- Overlap:
  - Loading continues during RUN until shadow_full.
  - A tile completed during RUN waits in the shadow buffer.
  - The IDLE cycle between tiles is mandatory; arr_rst is high for at least 1 cycle so the array clears.
- Commit and s_ready: the commit edge clears shadow_full, so s_ready rises the cycle after commit. No beat is lost or overwritten.
- in_flat/fil_flat are stable for the whole RUN window.
- Reset mid-RUN or mid-load: immediate return to reset values. The partial tile is lost and arr_rst=1 asynchronously.

Optional Feature:
- Macro: SYSTOLIC_LOADER_ERRCNT_EN.
- Defined: adds output err_cnt (8 bits), reset 0, increments on each err_len pulse, saturates at 255.
- Undefined: port and counter absent; err_len behaviour unchanged.

Test Plan:
- Stream 1..16 then nine 1s, s_last on beat 24:
  - in_flat element(0,0)=1, (3,3)=16; all fil_flat elements=1.
  - arr_rst low exactly 24 cycles; one tile_done.
  - Downstream array c11=54 after the window.
- Two back-to-back tiles, second streamed during RUN of the first:
  - s_ready drops after the 25th beat of tile 2.
  - Tile 2 commits one IDLE cycle after tile 1's tile_done.
  - in_flat unchanged during tile 1's RUN.
- s_last asserted on beat 20:
  - err_len pulses once; no commit, arr_rst stays 1.
  - A following correct 25-beat tile commits normally.
- 25 beats with no s_last:
  - err_len pulses.
  - With SYSTOLIC_LOADER_ERRCNT_EN, err_cnt=1; after 256 such errors err_cnt=255.
- rst driven low at RUN cycle 10:
  - arr_rst=1, in_flat=0, busy=0 immediately.
  - After release, a new tile loads from beat 0.
- s_valid toggled every other cycle:
  - Only handshaked beats are counted.
  - Final packing identical to the first scenario.
